// File: rtl/pong_match_ctrl_if.sv
// rtl/pong_match_ctrl_if.sv - Match controller signal bundle
//
// Groups the keyboard, ball-miss and match-status signals of pong_match_ctrl.
// Ports:
//   keycode     8  current keyboard keycode, 0 = no key
//   miss_left   1  ball passed left paddle (point to player 2)
//   miss_right  1  ball passed right paddle (point to player 1)
//   round_reset 1  one-frame strobe at the start of every serve
//   play_en     1  ball motion enable
//   serve_dir   1  0 = serve left, 1 = serve right
//   score1      4  left player score
//   score2      4  right player score
//   game_over   1  high while in GAMEOVER
//   winner      2  0 = none, 1 = player 1, 2 = player 2
//   state       3  current state encoding
// Modports: slave = the controller, master = the surrounding datapath.
interface pong_match_ctrl_if;
    logic [7:0] keycode;
    logic       miss_left;
    logic       miss_right;
    logic       round_reset;
    logic       play_en;
    logic       serve_dir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state;

    modport slave (
        input  keycode, miss_left, miss_right,
        output round_reset, play_en, serve_dir, score1, score2,
               game_over, winner, state
    );

    modport master (
        output keycode, miss_left, miss_right,
        input  round_reset, play_en, serve_dir, score1, score2,
               game_over, winner, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer and score keeper
//
// Steps once per video frame through ATTRACT, SERVE, PLAY, POINT and
// GAMEOVER, keeps both scores, and drives round_reset / play_en / serve_dir
// for the paddle and ball blocks.
// Ports:
//   frame_clk  in   frame clock, rising edge
//   Reset      in   asynchronous active-high reset
//   bus        slave modport of pong_match_ctrl_if (keys, misses, status)
// Optional feature macro: PONG_PAUSE_EN adds the PAUSE state (encoding 5),
// toggled by a KEY_PAUSE edge while in PLAY.
module pong_match_ctrl #(
    parameter int         WIN_SCORE   = 7,
    parameter int         SERVE_DELAY = 60,
    parameter int         POINT_HOLD  = 90,
    parameter logic [7:0] KEY_START   = 8'h2C,
    parameter logic [7:0] KEY_PAUSE   = 8'h13
) (
    input  logic               frame_clk,
    input  logic               Reset,
    pong_match_ctrl_if.slave   bus
);

    localparam logic [2:0] ST_ATTRACT  = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_POINT    = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;
`ifdef PONG_PAUSE_EN
    localparam logic [2:0] ST_PAUSE    = 3'd5;
`endif

    localparam int         CNT_MAX    = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int         CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);
    localparam logic [CW-1:0] POINT_LAST = CW'(POINT_HOLD - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_prev_key;
    logic [3:0]    r_score1;
    logic [3:0]    r_score2;
    logic          r_serve_dir;
    logic [1:0]    r_winner;
    logic          r_round_reset;
    logic          r_play_en;

    logic [2:0]    w_next_state;
    logic          w_start_pulse;
    logic          w_any_miss;
    logic          w_win_reached;

    assign w_start_pulse = (bus.keycode == KEY_START) && (r_prev_key != KEY_START);
    assign w_any_miss    = bus.miss_left | bus.miss_right;
    assign w_win_reached = (r_score1 >= WIN) || (r_score2 >= WIN);

`ifdef PONG_PAUSE_EN
    logic w_pause_pulse;
    assign w_pause_pulse = (bus.keycode == KEY_PAUSE) && (r_prev_key != KEY_PAUSE);
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ATTRACT:  if (w_start_pulse) w_next_state = ST_SERVE;
            ST_SERVE:    if (r_cnt == SERVE_LAST) w_next_state = ST_PLAY;
            ST_PLAY: begin
                // A miss in the same frame as a pause key wins: the point stands.
                if (w_any_miss) w_next_state = ST_POINT;
`ifdef PONG_PAUSE_EN
                else if (w_pause_pulse) w_next_state = ST_PAUSE;
`endif
            end
            ST_POINT:    if (r_cnt == POINT_LAST)
                             w_next_state = w_win_reached ? ST_GAMEOVER : ST_SERVE;
            ST_GAMEOVER: if (w_start_pulse) w_next_state = ST_SERVE;
`ifdef PONG_PAUSE_EN
            ST_PAUSE:    if (w_pause_pulse) w_next_state = ST_PLAY;
`endif
            default:     w_next_state = ST_ATTRACT;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_ATTRACT;
            r_cnt         <= '0;
            r_prev_key    <= 8'h00;
            r_score1      <= 4'd0;
            r_score2      <= 4'd0;
            r_serve_dir   <= 1'b1;
            r_winner      <= 2'd0;
            r_round_reset <= 1'b0;
            r_play_en     <= 1'b0;
        end else begin
            r_prev_key <= bus.keycode;
            r_state    <= w_next_state;

            // Only the timed states count; the counter restarts on any state change.
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (r_state == ST_SERVE || r_state == ST_POINT)
                r_cnt <= r_cnt + 1'b1;

            // Registered from next state so the strobe and enable line up
            // exactly with the state register, without a frame of lag.
            // PAUSE->PLAY is not a SERVE entry, so it never strobes.
            r_round_reset <= (w_next_state == ST_SERVE) && (r_state != ST_SERVE);
            r_play_en     <= (w_next_state == ST_PLAY);

            // A double miss is a replay: it still leaves PLAY but scores nothing.
            if (r_state == ST_PLAY && (bus.miss_left ^ bus.miss_right)) begin
                if (bus.miss_right) begin
                    if (r_score1 != 4'd15) r_score1 <= r_score1 + 4'd1;
                    r_serve_dir <= 1'b1;
                end else begin
                    if (r_score2 != 4'd15) r_score2 <= r_score2 + 4'd1;
                    r_serve_dir <= 1'b0;
                end
            end

            if (r_state == ST_POINT && w_next_state == ST_GAMEOVER)
                r_winner <= (r_score1 >= WIN) ? 2'd1 : 2'd2;

            if (r_state == ST_GAMEOVER && w_start_pulse) begin
                r_score1 <= 4'd0;
                r_score2 <= 4'd0;
                r_winner <= 2'd0;
            end
        end
    end

    assign bus.state       = r_state;
    assign bus.round_reset = r_round_reset;
    assign bus.play_en     = r_play_en;
    assign bus.serve_dir   = r_serve_dir;
    assign bus.score1      = r_score1;
    assign bus.score2      = r_score2;
    assign bus.winner      = r_winner;
    assign bus.game_over   = (r_state == ST_GAMEOVER);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - Directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    pong_match_ctrl_if bus ();

    pong_match_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_seen;
    int pe_seen;
    int bad_state;

    task automatic chk(input string tag, input int observed, input int expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one frame; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Advance n frames, counting round_reset / play_en highs and frames
    // that are not in the expected state.
    task automatic run(input int n, input int exp_state);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.round_reset === 1'b1) rr_seen++;
            if (bus.play_en === 1'b1) pe_seen++;
            if (bus.state !== 3'(exp_state)) bad_state++;
        end
    endtask

    // From the first SERVE frame, run to the first PLAY frame.
    task automatic serve_to_play(input string tag);
        rr_seen = 0; pe_seen = 0; bad_state = 0;
        run(59, 1);
        chk({tag, "_serve_hold"}, bad_state + rr_seen + pe_seen, 0);
        tick();
        chk({tag, "_play"}, int'(bus.state), 2);
    endtask

    // From the first POINT frame, run to the frame after POINT ends.
    task automatic point_out(input string tag, input int exp_state);
        rr_seen = 0; pe_seen = 0; bad_state = 0;
        run(89, 3);
        chk({tag, "_point_hold"}, bad_state + pe_seen, 0);
        tick();
        chk({tag, "_after_point"}, int'(bus.state), exp_state);
    endtask

    initial begin
        bus.keycode    = 8'h00;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;

        tick();
        tick();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_scores", int'({bus.score1, bus.score2}), 0);
        chk("rst_rr_pe", int'({bus.round_reset, bus.play_en}), 0);
        chk("rst_serve_dir", int'(bus.serve_dir), 1);
        chk("rst_winner_go", int'({bus.winner, bus.game_over}), 0);
        Reset = 1'b0;
        tick();
        chk("attract_idle", int'(bus.state), 0);

        // Held start key: one SERVE entry, play_en 60 frames later.
        bus.keycode = 8'h2C;
        tick();
        chk("start_serve", int'(bus.state), 1);
        chk("start_rr", int'(bus.round_reset), 1);
        rr_seen = 0; pe_seen = 0; bad_state = 0;
        run(9, 1);
        bus.keycode = 8'h00;
        run(50, 1);
        chk("start_single_rr", rr_seen, 0);
        chk("start_no_pe_early", pe_seen + bad_state, 0);
        tick();
        chk("start_pe_rise", int'({bus.state, bus.play_en}), 5);

        // miss_right: point to player 1.
        bus.miss_right = 1'b1;
        tick();
        bus.miss_right = 1'b0;
        chk("mr_point", int'(bus.state), 3);
        chk("mr_score", int'({bus.score1, bus.score2}), 8'h10);
        chk("mr_dir", int'(bus.serve_dir), 1);
        // miss in POINT ignored
        bus.miss_right = 1'b1;
        tick();
        bus.miss_right = 1'b0;
        rr_seen = 0; pe_seen = 0; bad_state = 0;
        run(88, 3);
        chk("mr_point_len", bad_state, 0);
        tick();
        chk("mr_reserve", int'({bus.state, bus.round_reset}), 3);
        chk("point_miss_ignored", int'(bus.score1), 1);
        // miss in SERVE ignored
        bus.miss_right = 1'b1;
        tick();
        bus.miss_right = 1'b0;
        chk("serve_miss_ignored", int'({bus.state, bus.score1}), 8'h11);
        rr_seen = 0; pe_seen = 0; bad_state = 0;
        run(58, 1);
        tick();
        chk("serve2_play", int'(bus.state), 2);

        // Double miss: replay.
        bus.miss_left  = 1'b1;
        bus.miss_right = 1'b1;
        tick();
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        chk("dbl_point", int'(bus.state), 3);
        chk("dbl_scores", int'({bus.score1, bus.score2}), 8'h10);
        chk("dbl_dir", int'(bus.serve_dir), 1);
        point_out("dbl", 1);
        serve_to_play("dbl");

        // Seven points to player 2.
        for (int k = 1; k <= 7; k++) begin
            bus.miss_left = 1'b1;
            tick();
            bus.miss_left = 1'b0;
            chk("ml_score2", int'(bus.score2), k);
            chk("ml_dir", int'(bus.serve_dir), 0);
            if (k < 7) begin
                point_out("ml", 1);
                serve_to_play("ml");
            end else begin
                point_out("ml_final", 4);
            end
        end
        chk("go_flags", int'({bus.winner, bus.game_over, bus.play_en}), 3'b101 << 1);
        chk("go_score1", int'(bus.score1), 1);
        // Game over holds without a key.
        tick();
        chk("go_hold", int'(bus.state), 4);
        bus.keycode = 8'h2C;
        tick();
        bus.keycode = 8'h00;
        chk("restart_state", int'({bus.state, bus.round_reset}), 3);
        chk("restart_clear", int'({bus.score1, bus.score2, bus.winner}), 0);
        serve_to_play("restart");

        // Reset mid-POINT (serve_dir is 0 here, so its return to 1 is visible).
        bus.miss_left = 1'b1;
        tick();
        bus.miss_left = 1'b0;
        chk("pre_rst_dir", int'({bus.state, bus.serve_dir}), 6);
        run(10, 3);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_scores", int'({bus.score1, bus.score2}), 0);
        chk("async_rst_dir_rr", int'({bus.serve_dir, bus.round_reset}), 2);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_rst_idle", int'({bus.state, bus.round_reset}), 0);

`ifdef PONG_PAUSE_EN
        bus.keycode = 8'h2C;
        tick();
        bus.keycode = 8'h00;
        serve_to_play("pause");
        bus.keycode = 8'h13;
        tick();
        bus.keycode = 8'h00;
        chk("pause_enter", int'({bus.state, bus.play_en}), 10);
        bus.miss_right = 1'b1;
        tick();
        bus.miss_right = 1'b0;
        chk("pause_miss_ignored", int'({bus.state, bus.score1}), 8'h50);
        bus.keycode = 8'h13;
        tick();
        bus.keycode = 8'h00;
        chk("pause_exit", int'({bus.state, bus.play_en, bus.round_reset}), 10);
`else
        // Pause key has no effect in the default build.
        bus.keycode = 8'h2C;
        tick();
        bus.keycode = 8'h00;
        serve_to_play("nopause");
        bus.keycode = 8'h13;
        tick();
        bus.keycode = 8'h00;
        chk("nopause_play", int'({bus.state, bus.play_en}), 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the Pong datapath; one step per frame_clk (one step per video frame).
- Owns the attract, serve, play, point and game-over sequence, and keeps both players' scores.
- Drives the round-reset strobe that recentres both paddles and the ball, plus the play enable and serve direction for the ball block.
- Inputs are keyboard keycodes and per-side ball-miss flags from the ball/collision logic.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_DELAY, 60, frames spent in SERVE before play starts; must be ≥1.
- POINT_HOLD, 90, frames spent in POINT after a miss; must be ≥1.
- KEY_START, 8'h2C, keycode that starts or restarts a match (Space).
- KEY_PAUSE, 8'h13, keycode that toggles pause (P); used only with the optional feature.

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  current keyboard keycode; 0 means no key.
- miss_left  in  1  ball passed the left paddle this frame; point to player 2.
- miss_right  in  1  ball passed the right paddle this frame; point to player 1.
- round_reset  out  1  one-frame strobe; drives the paddle resetB and the ball recentre.
- play_en  out  1  ball motion enable.
- serve_dir  out  1  0 = serve toward left, 1 = serve toward right.
- score1  out  4  left player score.
- score2  out  4  right player score.
- game_over  out  1  high while in GAMEOVER.
- winner  out  2  0 = none, 1 = player 1, 2 = player 2.
- state  out  3  current state encoding, for debug and on-screen text.

Behaviour:
- Reset values: state=ATTRACT(0), scores=0, round_reset=0, play_en=0, serve_dir=1, winner=0, game_over=0, frame counter=0, previous-keycode register=0.
- Start key edge: start_pulse = (keycode==KEY_START) && (prev_keycode!=KEY_START). prev_keycode is registered every frame.
- A held key produces exactly one start_pulse.
- States and transitions:
  - ATTRACT(0): start_pulse → SERVE.
  - SERVE(1): counter runs 0..SERVE_DELAY-1; at SERVE_DELAY-1 → PLAY.
  - PLAY(2): any miss → POINT.
  - POINT(3): counter runs 0..POINT_HOLD-1; at the end → GAMEOVER if either score ≥ WIN_SCORE, else → SERVE.
  - GAMEOVER(4): start_pulse clears scores and winner, then → SERVE.
- Counter: frame counter is cleared on every state change.
- round_reset: registered; high for exactly the first frame of every SERVE visit, otherwise 0.
- play_en: equals (state==PLAY), registered, with no extra latency.
- Scoring is evaluated only in PLAY; misses in any other state are ignored.
  - miss_right alone: score1+1, serve_dir←1 (ball goes toward player 2, who conceded).
  - miss_left alone: score2+1, serve_dir←0.
  - Both misses in the same frame: no score change, serve_dir unchanged, still → POINT (replay).
- Score update: registered on the PLAY→POINT edge. Scores saturate at 15 and never wrap.
- winner: set on the POINT→GAMEOVER transition (1 if score1 ≥ WIN_SCORE, else 2). Held until start_pulse.
- Keycodes other than KEY_START (and KEY_PAUSE when enabled) have no effect on this block.
- Reset asserted in any state returns all outputs to reset values immediately; round_reset is not pulsed by Reset itself.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- Defined:
  - Adds state PAUSE(5).
  - A KEY_PAUSE edge in PLAY → PAUSE, with play_en=0.
  - A KEY_PAUSE edge in PAUSE → PLAY, with no round_reset and no score change.
  - Misses are ignored in PAUSE.
- Undefined: KEY_PAUSE is ignored, encoding 5 is unreachable, and no pause logic is synthesised.

Test Plan:
- Reset, then keycode=8'h2C held for 10 frames → exactly one SERVE entry, round_reset high for 1 frame, play_en rises SERVE_DELAY frames after SERVE entry.
- In PLAY, pulse miss_right for 1 frame → score1=1, serve_dir=1, POINT for 90 frames, then SERVE with round_reset pulse.
- In PLAY, assert miss_left and miss_right together → scores unchanged, serve_dir unchanged, POINT then SERVE.
- Six miss_left points, then a seventh → score2=7, state=GAMEOVER, winner=2, game_over=1, play_en=0. Start edge → scores=0, winner=0, SERVE.
- Pulse miss_right while in SERVE or POINT → no score change. Assert Reset mid-POINT → ATTRACT, scores 0, serve_dir=1.
- With PONG_PAUSE_EN defined: 8'h13 edge in PLAY → state 5, play_en=0, misses ignored; second 8'h13 edge → PLAY, no round_reset.
